// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end that sequences ops through the shared ALU
module alu_arbiter #(
    parameter int MUL_LAT = 1,
    parameter int DIV_LAT = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_src1,
    input  logic [31:0] req0_src2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_src1,
    input  logic [31:0] req1_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [31:0] rsp_rem,
    output logic        rsp_err,
    output logic [13:0] alu_control,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    input  logic [31:0] alu_result,
    input  logic [31:0] div_odd
);
    localparam int CW = $clog2((DIV_LAT > MUL_LAT ? DIV_LAT : MUL_LAT) + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d, id_q, id_d, err_q, err_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   src1_q, src1_d, src2_q, src2_d, res_q, res_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          any, gnt, bad;
    logic [3:0]    op_in;
    logic [31:0]   s1_in, s2_in;

    // Pick the winner: sole requester, or the one not granted last on a tie
    always_comb begin
        any   = req0_valid | req1_valid;
        gnt   = (req0_valid & req1_valid) ? ~last_q : req1_valid;
        op_in = gnt ? req1_op : req0_op;
        s1_in = gnt ? req1_src1 : req0_src1;
        s2_in = gnt ? req1_src2 : req0_src2;
        bad   = (op_in > 4'd13) || (op_in == 4'd3 && s2_in == '0);
    end

    // Sequencer: accept in IDLE, count out the op latency in EXEC, hold the response in RESP
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        err_d   = err_q;
        op_d    = op_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        res_d   = res_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && any) begin
            last_d  = gnt;
            id_d    = gnt;
            op_d    = op_in;
            src1_d  = s1_in;
            src2_d  = s2_in;
            cnt_d   = op_in == 4'd3 ? CW'(DIV_LAT - 1) : op_in == 4'd2 ? CW'(MUL_LAT - 1) : '0;
            res_d   = '0;
            rem_d   = '0;
            err_d   = bad;
            state_d = bad ? RESP : EXEC;
        end else if (state_q == EXEC) begin
            if (cnt_q == '0) begin
                res_d   = alu_result;
                rem_d   = op_q == 4'd3 ? div_odd : '0;
                err_d   = 1'b0;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (state_q == RESP && rsp_ready) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            err_q   <= err_d;
            op_q    <= op_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req0_ready  = ~reset & (state_q == IDLE) & any & ~gnt;
    assign req1_ready  = ~reset & (state_q == IDLE) & gnt;
    assign rsp_valid   = state_q == RESP;
    assign rsp_id      = id_q;
    assign rsp_result  = res_q;
    assign rsp_rem     = rem_q;
    assign rsp_err     = err_q;
    assign alu_control = state_q == EXEC ? 14'(1) << op_q : '0;
    assign alu_src1    = src1_q;
    assign alu_src2    = src2_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a latency-aware ALU model and arbitration model
module tb_alu_arbiter;
    localparam int ML = 2, DL = 33;

    logic        clk = 1'b0, reset = 1'b1;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_result, rsp_rem, alu_src1, alu_src2, alu_result, div_odd;
    logic [13:0] alu_control;

    typedef struct {logic [3:0] op; logic [31:0] a; logic [31:0] b;} req_t;
    typedef struct {logic id; logic [31:0] res; logic [31:0] rem; logic err; int acc; int lat;} exp_t;

    req_t p0[$], p1[$];
    exp_t sb[$];
    logic lg_m = 1'b1;
    int   rr_mode = 1, tests = 0, fails = 0, cyc = 0;

    alu_arbiter #(.MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result), .div_odd(div_odd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latf(input logic [3:0] op);
        return op == 4'd3 ? DL : op == 4'd2 ? ML : 1;
    endfunction

    function automatic logic [31:0] f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return b == 0 ? 32'd0 : a / b;
            4'd4:  return {31'b0, $signed(a) < $signed(b)};
            4'd5:  return {31'b0, a < b};
            4'd6:  return a & b;
            4'd7:  return ~(a | b);
            4'd8:  return a | b;
            4'd9:  return a ^ b;
            4'd10: return a << b[4:0];
            4'd11: return a >> b[4:0];
            4'd12: return $signed(a) >>> b[4:0];
            4'd13: return b << 16;
            default: return 32'd0;
        endcase
    endfunction

    // ALU stand-in: results only appear once the control and operands have been held for the op latency
    logic [3:0]  aop;
    int          cur, hc;
    logic [13:0] pc;
    logic [31:0] pa, pb;
    always_comb begin
        aop = 4'd15;
        for (int i = 0; i < 14; i++) if (alu_control[i]) aop = 4'(i);
        cur = 0;
        if (alu_control != 0) cur = (alu_control == pc && alu_src1 == pa && alu_src2 == pb) ? hc + 1 : 1;
        alu_result = (cur == latf(aop)) ? f(aop, alu_src1, alu_src2) : 32'hDEADBEEF;
        div_odd = (cur == latf(aop) && aop == 4'd3 && alu_src2 != 0) ? alu_src1 % alu_src2 : 32'h0BADD0DD;
    end
    always @(posedge clk) begin
        hc <= cur;
        pc <= alu_control;
        pa <= alu_src1;
        pb <= alu_src2;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic id, input req_t r, input int acc);
        exp_t e;
        e.id = id;
        e.acc = acc;
        if (r.op > 4'd13 || (r.op == 4'd3 && r.b == 0)) begin
            e.res = 0; e.rem = 0; e.err = 1'b1; e.lat = 0;
        end else begin
            e.res = f(r.op, r.a, r.b);
            e.rem = r.op == 4'd3 ? r.a % r.b : 32'd0;
            e.err = 1'b0;
            e.lat = latf(r.op);
        end
        return e;
    endfunction

    task automatic book();
        logic w;
        if (reset || !(req0_ready || req1_ready)) return;
        if (!(req0_valid || req1_valid)) begin
            chk("spurious ready", {req1_ready, req0_ready}, 2'b00);
            return;
        end
        w = (req0_valid && req1_valid) ? ~lg_m : req1_valid;
        chk("grant", {req1_ready, req0_ready}, w ? 2'b10 : 2'b01);
        lg_m = w;
        if (w) begin
            sb.push_back(model(1'b1, p1[0], cyc));
            void'(p1.pop_front());
        end else begin
            sb.push_back(model(1'b0, p0[0], cyc));
            void'(p0.pop_front());
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        req0_valid = p0.size() > 0;
        req1_valid = p1.size() > 0;
        req0_op = 0; req0_src1 = 0; req0_src2 = 0;
        req1_op = 0; req1_src1 = 0; req1_src2 = 0;
        if (p0.size() > 0) begin req0_op = p0[0].op; req0_src1 = p0[0].a; req0_src2 = p0[0].b; end
        if (p1.size() > 0) begin req1_op = p1[0].op; req1_src1 = p1[0].a; req1_src2 = p1[0].b; end
        rsp_ready = rr_mode == 2 ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
        @(negedge clk);
        book();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((p0.size() > 0 || p1.size() > 0 || sb.size() > 0 || rsp_valid) && k < budget) begin
            cycle();
            k++;
        end
        chk("drain timeout", k < budget, 1'b1);
    endtask

    // Monitor: response timing, stall stability, and scoreboard comparison on each handshake
    initial begin
        logic pv = 1'b0;
        logic [65:0] saved = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
            end else begin
                if (rsp_valid || alu_control != 0) chk("ready while busy", {req1_ready, req0_ready}, 2'b00);
                if (rsp_valid) chk("alu_control in resp", alu_control, 14'h0);
                if (pv) begin
                    chk("stall valid drop", rsp_valid, 1'b1);
                    chk("stall hold", {rsp_id, rsp_err, rsp_result, rsp_rem}, saved);
                end else if (rsp_valid) begin
                    if (sb.size() == 0) chk("unexpected rsp", 1'b1, 1'b0);
                    else chk("rsp latency", cyc - sb[0].acc, sb[0].lat + 1);
                end
                if (rsp_valid && rsp_ready && sb.size() > 0) begin
                    chk("rsp_id", rsp_id, sb[0].id);
                    chk("rsp_result", rsp_result, sb[0].res);
                    chk("rsp_rem", rsp_rem, sb[0].rem);
                    chk("rsp_err", rsp_err, sb[0].err);
                    void'(sb.pop_front());
                end
                pv = rsp_valid && !rsp_ready;
                saved = {rsp_id, rsp_err, rsp_result, rsp_rem};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, sent;
        logic [65:0] hold;
        req0_valid = 0; req0_op = 0; req0_src1 = 0; req0_src2 = 0;
        req1_valid = 0; req1_op = 0; req1_src1 = 0; req1_src2 = 0;
        rsp_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ctrl", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, alu_control}, 0);
        chk("reset data", {rsp_result, rsp_rem, alu_src1, alu_src2}, 0);
        reset = 0;

        for (int i = 0; i < 3; i++) begin
            p0.push_back('{4'd6, 32'h0F, 32'hFF});
            p1.push_back('{4'd9, 32'hA, 32'h5});
        end
        drain(100);

        p0.push_back('{4'd0, 32'h2223, 32'h2222});
        cycle();
        chk("add accept", req0_ready, 1'b1);
        cycle();
        chk("add control", alu_control, 14'h0001);
        cycle();
        chk("add rsp_valid", rsp_valid, 1'b1);
        chk("add result", rsp_result, 32'h4445);
        drain(20);

        p1.push_back('{4'd3, 32'd564, 32'd7});
        n = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (alu_control == 14'h0008) n++;
        end
        chk("div control cycles", n, 33);
        drain(20);

        rr_mode = 0;
        p0.push_back('{4'd8, 32'h1234, 32'h8});
        p1.push_back('{4'd1, 32'd5, 32'd3});
        n = 0;
        while (!rsp_valid && n < 20) begin cycle(); n++; end
        chk("stall rsp seen", rsp_valid, 1'b1);
        hold = {rsp_id, rsp_err, rsp_result, rsp_rem};
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall readies", {req1_ready, req0_ready}, 2'b00);
            chk("stall rsp fields", {rsp_id, rsp_err, rsp_result, rsp_rem}, hold);
        end
        rr_mode = 1;
        drain(50);

        p0.push_back('{4'd14, 32'd1, 32'd2});
        cycle();
        chk("illegal ctl c0", alu_control, 14'h0);
        cycle();
        chk("illegal rsp_valid", rsp_valid, 1'b1);
        chk("illegal rsp_err", rsp_err, 1'b1);
        chk("illegal ctl c1", alu_control, 14'h0);
        drain(20);
        p1.push_back('{4'd3, 32'd100, 32'd0});
        drain(20);

        p0.push_back('{4'd3, 32'd1000, 32'd3});
        cycle();
        repeat (10) cycle();
        reset = 1;
        p0.delete(); p1.delete(); sb.delete();
        lg_m = 1'b1;
        cycle();
        chk("midreset ctrl", {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, alu_control}, 0);
        chk("midreset data", {rsp_result, rsp_rem, alu_src1, alu_src2}, 0);
        reset = 0;
        p0.push_back('{4'd0, 32'd7, 32'd8});
        p1.push_back('{4'd0, 32'd1, 32'd2});
        drain(30);

        rr_mode = 2;
        sent = 0;
        for (int k = 0; k < 4000 && sent < 80; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                req_t r;
                r.op = 4'($urandom_range(0, 15));
                r.a = $urandom;
                r.b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                if ($urandom_range(0, 1) == 0) begin
                    if (p0.size() < 2) begin p0.push_back(r); sent++; end
                end else if (p1.size() < 2) begin
                    p1.push_back(r); sent++;
                end
            end
            cycle();
        end
        drain(4000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU. It accepts operation requests from two requesters over valid/ready handshakes and grants the ALU round-robin. It drives the ALU's one-hot `alu_control` and operands for the op's fixed latency, then returns `alu_result`/`div_odd` on a single tagged response channel. It sits between the issue logic and the `alu` instance; the ALU itself is unchanged.

## Interface
- `MUL_LAT`, default 1: number of ALU cycles a multiply occupies (≥1).
- `DIV_LAT`, default 33: number of ALU cycles a divide occupies (≥1).
- `clk` input 1: the block's only clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req0_valid`, `req1_valid` input 1 each: requester has an op pending.
- `req0_ready`, `req1_ready` output 1 each: one-cycle accept pulse.
- `req0_op`, `req1_op` input 4 each: op index, encoded as listed under Operation.
- `req0_src1`, `req0_src2`, `req1_src1`, `req1_src2` input 32 each: operands.
- `rsp_valid` output 1: response held until it is taken.
- `rsp_ready` input 1: the response consumer takes the response.
- `rsp_id` output 1: which requester the response belongs to (0 or 1).
- `rsp_result` output 32: captured `alu_result`.
- `rsp_rem` output 32: captured `div_odd`; 0 for every op other than divide.
- `rsp_err` output 1: set for an illegal op or a divide by zero.
- `alu_control` output 14: one-hot op select to the ALU; 0 when the ALU is idle.
- `alu_src1`, `alu_src2` output 32 each: registered operands to the ALU.
- `alu_result`, `div_odd` input 32 each: ALU results.

## Operation
- **Op encoding.** Op index i drives `alu_control = 1<<i`.
  - 0 add, 1 sub, 2 mul, 3 div, 4 slt, 5 sltu, 6 and, 7 nor, 8 or, 9 xor, 10 sll, 11 srl, 12 sra, 13 lui.
  - 14 and 15 are illegal.
- **Latency.** Divide occupies the ALU for `DIV_LAT` cycles, multiply for `MUL_LAT`, and every other op for 1 cycle.
- **State machine.** States are IDLE, EXEC and RESP.
  - **IDLE.** If any `reqN_valid` is high, grant one requester, pulse its `reqN_ready` for that cycle, and register the op, operands and id.
    - Legal op with nonzero divisor: load the latency counter to L−1 and go to EXEC.
    - Illegal op, or div with `src2==0`: do not issue to the ALU. Load `rsp_result=0`, `rsp_rem=0`, `rsp_err=1` and go to RESP.
  - **EXEC.** `alu_control` is one-hot and the operands are held stable.
    - The counter decrements each cycle.
    - When the counter is 0, capture `alu_result` (and `div_odd` if the op is div, else 0) with `rsp_err=0`, then go to RESP.
  - **RESP.** `alu_control=0`. `rsp_valid=1`; `rsp_*` are held stable until `rsp_valid && rsp_ready`, then go to IDLE.
- **Arbitration.** Round-robin using a `last_grant` register.
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not `last_grant` wins.
  - `last_grant` updates on each grant. Its reset value is 1, so req0 wins the first tie.
- **Acceptance.** At most one request is outstanding. Both `reqN_ready` are 0 in EXEC and RESP. A requester that is not granted keeps its valid asserted and its payload stable.
- **Widths.** Operands and results are passed through unmodified; the block does no arithmetic on them.

## Timing
- **Reset values.** All outputs are 0, state is IDLE, and `last_grant=1`.
- **Reset mid-operation.** Reset asserted in any state aborts the op. No response is produced, and all outputs are 0 on the cycle after the reset edge.
- **Legal op of latency L accepted in cycle 0.**
  - `alu_control` is valid in cycles 1..L.
  - The result is captured at the end of cycle L.
  - `rsp_valid` rises in cycle L+1.
- **Error path.** An error op accepted in cycle 0 has `rsp_valid` in cycle 1, and `alu_control` stays 0 throughout.
- **Zero-stall response.** If `rsp_ready` is already high when `rsp_valid` rises, the response completes in cycle L+1. The next accept can occur no earlier than cycle L+2 (the IDLE cycle).
- **Back-to-back throughput.** The minimum interval between accepts is L+2 cycles.
- **Response stall.** Under `rsp_ready=0`, `rsp_*` and `alu_control=0` are constant, and no `reqN_ready` is asserted.
- **Simultaneous events.** A request arriving while the block is in RESP with a completing handshake is not accepted in that cycle; it is accepted in the following IDLE cycle.

## Test plan
- **Single add.** req0 add with src1=0x2223, src2=0x2222 → `req0_ready` pulses in cycle 0, `alu_control=0x0001` in cycle 1, and in cycle 2 `rsp_valid=1`, `rsp_id=0`, `rsp_result=0x4445`, `rsp_rem=0`, `rsp_err=0`.
- **Divide with `DIV_LAT=33`.** req1 div 564/7 → `alu_control=0x0008` for exactly 33 cycles, then `rsp_result=80`, `rsp_rem=4`, `rsp_id=1`, with `rsp_valid` in cycle 34.
- **Tie arbitration.** Both requesters valid from reset, each issuing three ops (req0 and 0x0F/0xFF, req1 xor 0xA/0x5) → grant order is 0,1,0,1,0,1, with results 0x0F and 0xF respectively.
- **Backpressure and errors.** Hold `rsp_ready=0` for 10 cycles after `rsp_valid` → `rsp_*` are unchanged and `req*_ready=0` throughout. Op 14 → `rsp_err=1` in cycle 1 with `alu_control` never nonzero. div by 0 → `rsp_err=1`, `rsp_result=0`.
- **Reset mid-divide.** Assert reset in cycle 10 of a divide → the next cycle has all outputs 0, no response is produced, and a following add completes normally with req0 winning a tie.
